// File: rtl/morse_pkg.sv
`default_nettype none
// ============================================================================
// Module : morse_pkg
// Brief  : FSM states, unit multipliers and the ITU character table for
//          the Morse LED sequencer.
// Rev    : 1.0
// ============================================================================
package morse_pkg;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DECODE   = 3'd1,
      ST_ELEM_ON  = 3'd2,
      ST_ELEM_GAP = 3'd3,
      ST_CHAR_GAP = 3'd4,
      ST_WORD_GAP = 3'd5
   } state_t;

   localparam logic [2:0] U_DOT      = 3'd1;
   localparam logic [2:0] U_DASH     = 3'd3;
   localparam logic [2:0] U_ELEM_GAP = 3'd1;
   localparam logic [2:0] U_CHAR_GAP = 3'd3;
   localparam logic [2:0] U_WORD_GAP = 3'd7;

   localparam logic [7:0] ASCII_SPACE = 8'h20;

   typedef struct packed {
      logic [2:0] len;
      logic [4:0] pattern;
      logic       valid;
   } morse_code_t;

   // Table entries are written in reading order (first element at bit len-1)
   // and flipped so that element 0 lands at the LSB of the returned pattern.
   function automatic morse_code_t morse_lookup(input logic [7:0] ch);
      logic [7:0]  c;
      logic [7:0]  ls;
      logic [4:0]  aligned;
      morse_code_t code;
      c = ch;
      if (c >= "a" && c <= "z") c = c - 8'h20;
      case (c)
         "A": ls = {3'd2, 5'b00001};  "B": ls = {3'd4, 5'b01000};
         "C": ls = {3'd4, 5'b01010};  "D": ls = {3'd3, 5'b00100};
         "E": ls = {3'd1, 5'b00000};  "F": ls = {3'd4, 5'b00010};
         "G": ls = {3'd3, 5'b00110};  "H": ls = {3'd4, 5'b00000};
         "I": ls = {3'd2, 5'b00000};  "J": ls = {3'd4, 5'b00111};
         "K": ls = {3'd3, 5'b00101};  "L": ls = {3'd4, 5'b00100};
         "M": ls = {3'd2, 5'b00011};  "N": ls = {3'd2, 5'b00010};
         "O": ls = {3'd3, 5'b00111};  "P": ls = {3'd4, 5'b00110};
         "Q": ls = {3'd4, 5'b01101};  "R": ls = {3'd3, 5'b00010};
         "S": ls = {3'd3, 5'b00000};  "T": ls = {3'd1, 5'b00001};
         "U": ls = {3'd3, 5'b00001};  "V": ls = {3'd4, 5'b00001};
         "W": ls = {3'd3, 5'b00011};  "X": ls = {3'd4, 5'b01001};
         "Y": ls = {3'd4, 5'b01011};  "Z": ls = {3'd4, 5'b01100};
         "0": ls = {3'd5, 5'b11111};  "1": ls = {3'd5, 5'b01111};
         "2": ls = {3'd5, 5'b00111};  "3": ls = {3'd5, 5'b00011};
         "4": ls = {3'd5, 5'b00001};  "5": ls = {3'd5, 5'b00000};
         "6": ls = {3'd5, 5'b10000};  "7": ls = {3'd5, 5'b11000};
         "8": ls = {3'd5, 5'b11100};  "9": ls = {3'd5, 5'b11110};
         default: ls = 8'd0;
      endcase
      aligned      = ls[4:0] << (3'd5 - ls[7:5]);
      code.len     = ls[7:5];
      code.valid   = (ls[7:5] != 3'd0);
      code.pattern = 5'd0;
      for (int i = 0; i < 5; i++) begin
         if (i < int'(ls[7:5])) code.pattern[i] = aligned[4-i];
      end
      return code;
   endfunction

endpackage
`default_nettype wire

// File: rtl/morse_if.sv
`default_nettype none
// ============================================================================
// Module : morse_if
// Brief  : Character handshake and LED/status bundle of the Morse sequencer.
// Rev    : 1.0
// ============================================================================
interface morse_if;
   logic [7:0] char_data;
   logic       char_valid;
   logic       char_ready;
   logic       abort;
   logic       led_n;
   logic       busy;
   logic       done;
   logic       err;

   modport master (
      output char_data, char_valid, abort,
      input  char_ready, led_n, busy, done, err
   );

   modport slave (
      input  char_data, char_valid, abort,
      output char_ready, led_n, busy, done, err
   );
endinterface
`default_nettype wire

// File: rtl/morse_unit_timer.sv
`default_nettype none
// ============================================================================
// Module : morse_unit_timer
// Brief  : Counts n*UNIT_CYCLES clocks after start and flags the last one.
// Rev    : 1.0
// ============================================================================
module morse_unit_timer #(
   parameter int UNIT_CYCLES = 4800000,
   parameter int CNT_W       = 23
) (
   input  wire logic       clk,
   input  wire logic       rst,
   input  wire logic       start,
   input  wire logic [2:0] load_n,
   input  wire logic       clear,
   output logic            expire
);
   localparam logic [CNT_W-1:0] C_UNIT_LAST = CNT_W'(UNIT_CYCLES - 1);

   logic [CNT_W-1:0] unit_q, unit_d;
   logic [2:0]       mult_q, mult_d;
   logic             active_q, active_d;

   assign expire = active_q && (unit_q == C_UNIT_LAST) && (mult_q == 3'd0);

   // A start coinciding with expire reloads, so back-to-back periods abut.
   always_comb begin
      unit_d   = unit_q;
      mult_d   = mult_q;
      active_d = active_q;
      if (clear) begin
         unit_d   = '0;
         mult_d   = 3'd0;
         active_d = 1'b0;
      end else if (start) begin
         unit_d   = '0;
         mult_d   = load_n - 3'd1;
         active_d = 1'b1;
      end else if (active_q) begin
         if (unit_q == C_UNIT_LAST) begin
            unit_d = '0;
            if (mult_q == 3'd0) active_d = 1'b0;
            else                mult_d   = mult_q - 3'd1;
         end else begin
            unit_d = unit_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         unit_q   <= '0;
         mult_q   <= 3'd0;
         active_q <= 1'b0;
      end else begin
         unit_q   <= unit_d;
         mult_q   <= mult_d;
         active_q <= active_d;
      end
   end
endmodule
`default_nettype wire

// File: rtl/morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module : morse_sequencer
// Brief  : Accepts ASCII characters and blinks them in Morse on an
//          active-low LED. rst is asynchronous and active-low.
// Rev    : 1.0
// ============================================================================
module morse_sequencer
   import morse_pkg::*;
#(
   parameter int UNIT_CYCLES = 4800000,
   parameter int CNT_W       = 23
) (
   input wire logic clk,
   input wire logic rst,
   morse_if.slave   bus
);
   state_t      state_q, state_d;
   logic [7:0]  char_q, char_d;
   logic [4:0]  pat_q, pat_d;
   logic [2:0]  remain_q, remain_d;
   logic        led_n_q, led_n_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        err_q, err_d;
   logic        w_ready;
   logic        tmr_start;
   logic [2:0]  tmr_n;
   logic        tmr_expire;
   morse_code_t w_code;

   assign w_ready = rst && (state_q == ST_IDLE) && !bus.abort;
   assign w_code  = morse_lookup(char_q);

   morse_unit_timer #(
      .UNIT_CYCLES (UNIT_CYCLES),
      .CNT_W       (CNT_W)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .start  (tmr_start),
      .load_n (tmr_n),
      .clear  (bus.abort),
      .expire (tmr_expire)
   );

   // pat_q shifts right per element so bit 0 is always the current one.
   always_comb begin
      state_d   = state_q;
      char_d    = char_q;
      pat_d     = pat_q;
      remain_d  = remain_q;
      done_d    = 1'b0;
      err_d     = 1'b0;
      tmr_start = 1'b0;
      tmr_n     = U_DOT;
      if (bus.abort && state_q != ST_IDLE) begin
         state_d = ST_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.char_valid && w_ready) begin
                  char_d  = bus.char_data;
                  state_d = ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (char_q == ASCII_SPACE) begin
                  state_d   = ST_WORD_GAP;
                  tmr_start = 1'b1;
                  tmr_n     = U_WORD_GAP;
               end else if (w_code.valid) begin
                  state_d   = ST_ELEM_ON;
                  pat_d     = w_code.pattern;
                  remain_d  = w_code.len - 3'd1;
                  tmr_start = 1'b1;
                  tmr_n     = w_code.pattern[0] ? U_DASH : U_DOT;
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end
            ST_ELEM_ON: begin
               if (tmr_expire) begin
                  tmr_start = 1'b1;
                  if (remain_q != 3'd0) begin
                     state_d = ST_ELEM_GAP;
                     tmr_n   = U_ELEM_GAP;
                  end else begin
                     state_d = ST_CHAR_GAP;
                     tmr_n   = U_CHAR_GAP;
                  end
               end
            end
            ST_ELEM_GAP: begin
               if (tmr_expire) begin
                  state_d   = ST_ELEM_ON;
                  pat_d     = pat_q >> 1;
                  remain_d  = remain_q - 3'd1;
                  tmr_start = 1'b1;
                  tmr_n     = pat_q[1] ? U_DASH : U_DOT;
               end
            end
            ST_CHAR_GAP, ST_WORD_GAP: begin
               if (tmr_expire) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
      led_n_d = (state_d != ST_ELEM_ON);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         char_q   <= 8'd0;
         pat_q    <= 5'd0;
         remain_q <= 3'd0;
         led_n_q  <= 1'b1;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         char_q   <= char_d;
         pat_q    <= pat_d;
         remain_q <= remain_d;
         led_n_q  <= led_n_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   assign bus.char_ready = w_ready;
   assign bus.led_n      = led_n_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.err        = err_q;
endmodule
`default_nettype wire

// File: tb/tb_morse_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_morse_sequencer
// Brief  : Self-checking bench; per-cycle LED/status traces are compared
//          against traces built from Morse dot/dash strings.
// Rev    : 1.0
// ============================================================================
module tb_morse_sequencer;
   localparam int UNIT = 4;
   localparam int TL   = 128;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   tests   = 0;
   int   fails   = 0;
   int   accepts = 0;

   morse_if bus();

   morse_sequencer #(.UNIT_CYCLES(UNIT), .CNT_W(3)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst && bus.char_valid && bus.char_ready) accepts++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic string morse_of(input logic [7:0] ch);
      logic [7:0] c;
      c = ch;
      if (c >= 8'h61 && c <= 8'h7a) c = c - 8'h20;
      case (c)
         "A": return ".-";    "B": return "-...";  "C": return "-.-.";
         "D": return "-..";   "E": return ".";     "F": return "..-.";
         "G": return "--.";   "H": return "....";  "I": return "..";
         "J": return ".---";  "K": return "-.-";   "L": return ".-..";
         "M": return "--";    "N": return "-.";    "O": return "---";
         "P": return ".--.";  "Q": return "--.-";  "R": return ".-.";
         "S": return "...";   "T": return "-";     "U": return "..-";
         "V": return "...-";  "W": return ".--";   "X": return "-..-";
         "Y": return "-.--";  "Z": return "--..";
         "0": return "-----"; "1": return ".----"; "2": return "..---";
         "3": return "...--"; "4": return "....-"; "5": return ".....";
         "6": return "-...."; "7": return "--..."; "8": return "---..";
         "9": return "----.";
         default: return "";
      endcase
   endfunction

   // Cycle 0 is the cycle after the accept edge; the last cycle is done/err.
   task automatic build_expected(input logic [7:0] c,
                                 output logic [TL-1:0] led, done, err, busy,
                                 output int len);
      string m;
      int    k;
      led = '1; done = '0; err = '0; busy = '0;
      m = morse_of(c);
      busy[0] = 1'b1;
      k = 1;
      if (c == 8'h20) begin
         repeat (7*UNIT) begin busy[k] = 1'b1; k++; end
         done[k] = 1'b1;
      end else if (m.len() == 0) begin
         err[k] = 1'b1;
      end else begin
         for (int i = 0; i < m.len(); i++) begin
            repeat ((m[i] == "-" ? 3 : 1) * UNIT) begin
               led[k] = 1'b0; busy[k] = 1'b1; k++;
            end
            if (i != m.len() - 1) repeat (UNIT) begin busy[k] = 1'b1; k++; end
         end
         repeat (3*UNIT) begin busy[k] = 1'b1; k++; end
         done[k] = 1'b1;
      end
      len = k + 1;
   endtask

   task automatic run_char(input logic [7:0] c, input bit hold, input logic [7:0] next_c,
                           input int len,
                           output logic [TL-1:0] led, done, err, busy, ready);
      led = '1; done = '0; err = '0; busy = '0; ready = '0;
      bus.char_data  = c;
      bus.char_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < len; k++) begin
         @(negedge clk);
         led[k] = bus.led_n; done[k] = bus.done; err[k] = bus.err;
         busy[k] = bus.busy; ready[k] = bus.char_ready;
         if (!hold && k == 0) bus.char_valid = 1'b0;
         if (hold && k == len - 1) bus.char_data = next_c;
      end
   endtask

   task automatic test_reset();
      bus.char_data = 8'd0; bus.char_valid = 1'b0; bus.abort = 1'b0;
      rst = 1'b0;
      repeat (3) @(negedge clk);
      tests++; if (bus.led_n !== 1'b1)      begin fails++; $display("FAIL reset_led_n: got %b want 1", bus.led_n); end
      tests++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      tests++; if (bus.done !== 1'b0)       begin fails++; $display("FAIL reset_done: got %b want 0", bus.done); end
      tests++; if (bus.err !== 1'b0)        begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
      tests++; if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL reset_ready: got %b want 0", bus.char_ready); end
      rst = 1'b1;
      #1;
      tests++; if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL post_reset_ready: got %b want 1", bus.char_ready); end
      @(negedge clk);
   endtask

   task automatic test_basic();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      int len;
      build_expected("E", el, ed, ee, eb, len);
      run_char("E", 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL E_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL E_done: got %h want %h", od, ed); end
      tests++; if (oe !== ee) begin fails++; $display("FAIL E_err: got %h want %h", oe, ee); end
      tests++; if (ob !== eb) begin fails++; $display("FAIL E_busy: got %h want %h", ob, eb); end
      repeat (2) @(negedge clk);
      build_expected("A", el, ed, ee, eb, len);
      run_char("a", 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL a_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL a_done: got %h want %h", od, ed); end
      tests++; if (ob !== eb) begin fails++; $display("FAIL a_busy: got %h want %h", ob, eb); end
      tests++; if (orr[len-1] !== 1'b1) begin fails++; $display("FAIL a_ready_at_done: got %b want 1", orr[len-1]); end
      @(negedge clk);
      tests++; if (bus.done !== 1'b0) begin fails++; $display("FAIL a_done_width: got %b want 0", bus.done); end
   endtask

   task automatic test_back_to_back();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      int len, a0;
      a0 = accepts;
      build_expected("0", el, ed, ee, eb, len);
      run_char("0", 1'b1, 8'h20, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL b2b_0_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL b2b_0_done: got %h want %h", od, ed); end
      build_expected(8'h20, el, ed, ee, eb, len);
      run_char(8'h20, 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL b2b_sp_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL b2b_sp_done: got %h want %h", od, ed); end
      tests++; if (ob !== eb) begin fails++; $display("FAIL b2b_sp_busy: got %h want %h", ob, eb); end
      repeat (4) @(negedge clk);
      tests++; if (accepts - a0 !== 2) begin fails++; $display("FAIL b2b_accepts: got %0d want 2", accepts - a0); end
   endtask

   task automatic test_unsupported();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      int len;
      build_expected("#", el, ed, ee, eb, len);
      run_char("#", 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (oe !== ee) begin fails++; $display("FAIL hash_err: got %h want %h", oe, ee); end
      tests++; if (od !== ed) begin fails++; $display("FAIL hash_done: got %h want %h", od, ed); end
      tests++; if (ol !== el) begin fails++; $display("FAIL hash_led: got %h want %h", ol, el); end
      @(negedge clk);
      tests++; if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL hash_ready: got %b want 1", bus.char_ready); end
      tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL hash_err_width: got %b want 0", bus.err); end
   endtask

   task automatic test_abort();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      int len;
      bit seen_done;
      build_expected("T", el, ed, ee, eb, len);
      ol = '1;
      bus.char_data = "T"; bus.char_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         ol[k] = bus.led_n;
         if (k == 0) bus.char_valid = 1'b0;
      end
      tests++; if (ol[5:0] !== el[5:0]) begin fails++; $display("FAIL abort_prefix_led: got %b want %b", ol[5:0], el[5:0]); end
      bus.abort = 1'b1;
      @(negedge clk);
      tests++; if (bus.led_n !== 1'b1)      begin fails++; $display("FAIL abort_led: got %b want 1", bus.led_n); end
      tests++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
      tests++; if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL abort_idle_ready: got %b want 0", bus.char_ready); end
      bus.abort = 1'b0;
      #1;
      tests++; if (bus.char_ready !== 1'b1) begin fails++; $display("FAIL abort_release_ready: got %b want 1", bus.char_ready); end
      seen_done = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.done || !bus.led_n) seen_done = 1'b1;
      end
      tests++; if (seen_done !== 1'b0) begin fails++; $display("FAIL abort_quiet: got activity %b want 0", seen_done); end
      build_expected("E", el, ed, ee, eb, len);
      run_char("E", 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL abort_E_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL abort_E_done: got %h want %h", od, ed); end
   endtask

   task automatic test_reset_mid();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      int len;
      bus.char_data = "O"; bus.char_valid = 1'b1;
      @(posedge clk);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         if (k == 0) bus.char_valid = 1'b0;
      end
      tests++; if (bus.led_n !== 1'b0) begin fails++; $display("FAIL rstmid_lit_before: got %b want 0", bus.led_n); end
      #2 rst = 1'b0;
      #1;
      tests++; if (bus.led_n !== 1'b1)      begin fails++; $display("FAIL rstmid_led_async: got %b want 1", bus.led_n); end
      tests++; if (bus.busy !== 1'b0)       begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.busy); end
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         tests++; if (bus.char_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready_c%0d: got %b want 0", k, bus.char_ready); end
      end
      rst = 1'b1;
      #1;
      tests++; if ({bus.led_n, bus.busy, bus.done, bus.err, bus.char_ready} !== 5'b10001) begin
         fails++; $display("FAIL rstmid_release: got %b want 10001", {bus.led_n, bus.busy, bus.done, bus.err, bus.char_ready});
      end
      @(negedge clk);
      build_expected("E", el, ed, ee, eb, len);
      run_char("E", 1'b0, 8'd0, len, ol, od, oe, ob, orr);
      tests++; if (ol !== el) begin fails++; $display("FAIL rstmid_E_led: got %h want %h", ol, el); end
      tests++; if (od !== ed) begin fails++; $display("FAIL rstmid_E_done: got %h want %h", od, ed); end
   endtask

   task automatic test_random();
      logic [TL-1:0] el, ed, ee, eb, ol, od, oe, ob, orr;
      logic [7:0] c;
      int len, r;
      string pool;
      pool = "ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmnopqrstuvwxyz0123456789";
      for (int n = 0; n < 14; n++) begin
         r = int'($urandom_range(0, 9));
         if (r < 1)      c = 8'h20;
         else if (r < 3) c = 8'($urandom_range(33, 126));
         else            c = pool[int'($urandom_range(0, 61))];
         repeat ($urandom_range(0, 3)) @(negedge clk);
         build_expected(c, el, ed, ee, eb, len);
         run_char(c, 1'b0, 8'd0, len, ol, od, oe, ob, orr);
         tests++; if (ol !== el) begin fails++; $display("FAIL rnd_led '%c': got %h want %h", c, ol, el); end
         tests++; if (od !== ed) begin fails++; $display("FAIL rnd_done '%c': got %h want %h", c, od, ed); end
         tests++; if (oe !== ee) begin fails++; $display("FAIL rnd_err '%c': got %h want %h", c, oe, ee); end
         tests++; if (ob !== eb) begin fails++; $display("FAIL rnd_busy '%c': got %h want %h", c, ob, eb); end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_unsupported();
      test_abort();
      test_reset_mid();
      test_random();
      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
